// File: rtl/deserializador_nibble.sv
// deserializador_nibble: serial-to-parallel front end for the 4-bit registro
// stage. Shifts in WIDTH bits MSB first under a bit_valid strobe. On frame
// completion it presents the word on Data_out together with a one-cycle load
// pulse. A frame that stalls for TIMEOUT cycles is aborted with frame_err.
//
// Optional feature macro: DESERIALIZADOR_PARITY_EN
//   When defined, every frame carries a trailing even-parity bit. A parity
//   failure aborts the frame with frame_err, just as a timeout does.
//
// Handshake: bit_valid/serial_in form a one-way strobe with no backpressure.
// A bit is consumed on every rising edge where bit_valid=1 and a frame is in
// RECV (or PAR). Strobes outside a frame are dropped, including one that
// arrives in the same cycle as start.
//
// state_dbg exposes the FSM state (0=IDLE, 1=RECV, 2=PAR) for checkers.

module deserializador_nibble #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             serial_in,
    output logic [WIDTH-1:0] Data_out,
    output logic             load,
    output logic             busy,
    output logic             frame_err,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [7:0]       IDLE_LAST = 8'(TIMEOUT - 1);

`ifdef DESERIALIZADOR_PARITY_EN
    // All data bits must be held until the parity bit has been checked.
    localparam int SH_W = WIDTH;
`else
    // The final data bit goes straight from serial_in to Data_out, so the
    // shift register only has to hold the first WIDTH-1 bits.
    localparam int SH_W = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1
`ifdef DESERIALIZADOR_PARITY_EN
        ,
        S_PAR  = 2'd2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [SH_W:0]     shift_word;

    // Next-state, datapath and output decode; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        data_d     = data_q;
        busy_d     = busy_q;
        load_d     = 1'b0;
        err_d      = 1'b0;
        shift_word = {shreg_q, serial_in};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RECV;
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end

            S_RECV: begin
                if (bit_valid) begin
                    shreg_d    = shift_word[SH_W-1:0];
                    idle_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef DESERIALIZADOR_PARITY_EN
                        state_d   = S_PAR;
`else
                        data_d    = shift_word[WIDTH-1:0];
                        load_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    idle_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end

`ifdef DESERIALIZADOR_PARITY_EN
            S_PAR: begin
                if (bit_valid) begin
                    idle_cnt_d = '0;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                    // Even parity: data bits plus parity bit XOR to zero.
                    if (^{shreg_q, serial_in} == 1'b0) begin
                        data_d = shreg_q;
                        load_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    idle_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            data_q     <= '0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            data_q     <= data_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign Data_out  = data_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign frame_err = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_deserializador_nibble.sv
// Testbench for deserializador_nibble: fixed vector table, hand-written
// sequences for reset, timeout and parity corners, then randomized traffic
// compared cycle by cycle against a frame-level reference model.

module tb_deserializador_nibble;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;
`ifdef DESERIALIZADOR_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, start, bit_valid, serial_in;
  logic [WIDTH-1:0] Data_out;
  logic load, busy, frame_err;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  deserializador_nibble #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .Data_out  (Data_out),
    .load      (load),
    .busy      (busy),
    .frame_err (frame_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame level: collect accepted bits in a queue, count silent cycles,
  // build the word arithmetically once enough bits have arrived.
  bit               m_in_frame = 1'b0;
  bit               m_bits[$];
  int               m_gap = 0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_load = 1'b0;
  logic             m_busy = 1'b0;
  logic             m_err  = 1'b0;

  task automatic model_step(input logic st, input logic bv, input logic sin,
                            input logic r);
    int ones;
    logic [WIDTH-1:0] w;
    m_load = 1'b0;
    m_err  = 1'b0;
    if (r) begin
      m_in_frame = 1'b0;
      m_bits.delete();
      m_gap  = 0;
      m_data = '0;
      m_busy = 1'b0;
    end else if (!m_in_frame) begin
      if (st) begin
        m_in_frame = 1'b1;
        m_bits.delete();
        m_gap  = 0;
        m_busy = 1'b1;
      end
    end else if (bv) begin
      m_bits.push_back(sin);
      m_gap = 0;
      if (m_bits.size() == FRAME_BITS) begin
        ones = 0;
        w    = '0;
        foreach (m_bits[i]) ones += int'(m_bits[i]);
        for (int i = 0; i < WIDTH; i++) w = (w << 1) | WIDTH'(m_bits[i]);
        if (FRAME_BITS == WIDTH || ones % 2 == 0) begin
          m_data = w;
          m_load = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_busy     = 1'b0;
        m_in_frame = 1'b0;
      end
    end else begin
      m_gap++;
      if (m_gap == TIMEOUT) begin
        m_err      = 1'b1;
        m_busy     = 1'b0;
        m_in_frame = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, let the edge happen, then compare all outputs
  // against the model 1 time unit after the edge.
  task automatic step(input logic st, input logic bv, input logic sin,
                      input logic r);
    start     = st;
    bit_valid = bv;
    serial_in = sin;
    rst       = r;
    @(posedge clk);
    #1;
    model_step(st, bv, sin, r);
    check_w("data_out", Data_out, m_data);
    check1("load", load, m_load);
    check1("busy", busy, m_busy);
    check1("frame_err", frame_err, m_err);
    check1("load_err_excl", load & frame_err, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Start a frame and send w MSB first, with 'gap' silent cycles before each
  // bit; in the parity build a correct even-parity bit follows.
  task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idle(gap);
      step(1'b0, 1'b1, w[i], 1'b0);
    end
`ifdef DESERIALIZADOR_PARITY_EN
    idle(gap);
    step(1'b0, 1'b1, ^w, 1'b0);
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic             st;
    logic             bv;
    logic             sin;
    logic             ld;
    logic [WIDTH-1:0] data;
    logic             bsy;
    logic             err;
  } vec_t;

  vec_t vt[11];

  initial begin
    int seg_bv_pct;

    start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0; rst = 1'b1;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check1("reset_state_idle", state_dbg == 2'd0, 1'b1);
    check_w("reset_data", Data_out, '0);

`ifndef DESERIALIZADOR_PARITY_EN
    // Columns: start bit_valid serial_in | load Data_out busy frame_err
    // 0: bit with start is dropped; 1-4: 1,0,1,1 -> B; 5: start in load
    // cycle; 6-9: 0,1,1,0 -> 6 with a mid-frame start in 7 and 9.
    vt[0]  = 10'b1_1_0_0_0000_1_0;
    vt[1]  = 10'b0_1_1_0_0000_1_0;
    vt[2]  = 10'b0_1_0_0_0000_1_0;
    vt[3]  = 10'b0_1_1_0_0000_1_0;
    vt[4]  = 10'b0_1_1_1_1011_0_0;
    vt[5]  = 10'b1_0_0_0_1011_1_0;
    vt[6]  = 10'b0_1_0_0_1011_1_0;
    vt[7]  = 10'b1_1_1_0_1011_1_0;
    vt[8]  = 10'b0_1_1_0_1011_1_0;
    vt[9]  = 10'b1_1_0_1_0110_0_0;
    vt[10] = 10'b0_0_0_0_0110_0_0;
    for (int i = 0; i < 11; i++) begin
      step(vt[i].st, vt[i].bv, vt[i].sin, 1'b0);
      check1("tbl_load", load, vt[i].ld);
      check_w("tbl_data", Data_out, vt[i].data);
      check1("tbl_busy", busy, vt[i].bsy);
      check1("tbl_err", frame_err, vt[i].err);
    end
`endif

    // Reset mid-frame: 2 bits in, 2 cycles later assert reset.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_w("midreset_data", Data_out, '0);
    check1("midreset_busy", busy, 1'b0);
    check1("midreset_load", load, 1'b0);
    check1("midreset_err", frame_err, 1'b0);
    idle(1);
    send_word(4'hA, 0);
    check1("after_reset_load", load, 1'b1);
    check_w("after_reset_data", Data_out, 4'hA);
    idle(1);
    check1("load_one_cycle", load, 1'b0);

    // Slow frame with 3-cycle gaps, then a stalled frame that times out.
    send_word(4'h6, 3);
    check1("gap_frame_load", load, 1'b1);
    check_w("gap_frame_data", Data_out, 4'h6);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(TIMEOUT - 1);
    check1("pre_timeout_err", frame_err, 1'b0);
    check1("pre_timeout_busy", busy, 1'b1);
    idle(1);
    check1("timeout_err", frame_err, 1'b1);
    check1("timeout_busy", busy, 1'b0);
    check1("timeout_load", load, 1'b0);
    check_w("timeout_data_kept", Data_out, 4'h6);
    idle(1);
    check1("timeout_err_one_cycle", frame_err, 1'b0);

    // Timeout counted from entry to RECV when no bit ever arrives.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TIMEOUT);
    check1("empty_frame_timeout", frame_err, 1'b1);

`ifdef DESERIALIZADOR_PARITY_EN
    // Good parity: 1,0,1,1 + 1 -> load B. Bad parity: 0,0,1,1 + 1 -> error.
    send_word(4'hB, 0);
    check1("par_ok_load", load, 1'b1);
    check_w("par_ok_data", Data_out, 4'hB);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check1("par_wait_busy", busy, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check1("par_bad_err", frame_err, 1'b1);
    check1("par_bad_load", load, 1'b0);
    check_w("par_bad_data_kept", Data_out, 4'hB);
    // Timeout while waiting for the parity bit.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(TIMEOUT);
    check1("par_timeout_err", frame_err, 1'b1);
`endif

    // Randomized traffic in segments of varying strobe density.
    for (int seg = 0; seg < 20; seg++) begin
      seg_bv_pct = $urandom_range(95, 5);
      for (int c = 0; c < 200; c++) begin
        step(($urandom_range(99, 0) < 20) ? 1'b1 : 1'b0,
             ($urandom_range(99, 0) < seg_bv_pct) ? 1'b1 : 1'b0,
             1'($urandom_range(1, 0)),
             ($urandom_range(299, 0) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
